alu_seq_exec: RTL and testbench
===============================

ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
Ports (name  direction  width  meaning):
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port ALU_control  input  3  operation code from the ALU decoder stage.
REQ-005 The block SHALL have port src_a  input  WIDTH  operand A.
REQ-006 The block SHALL have port src_b  input  WIDTH  operand B.
REQ-007 The block SHALL have port in_valid  input  1  operation request valid.
REQ-008 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-009 The block SHALL have port result  output  WIDTH  operation result.
REQ-010 The block SHALL have port zero  output  1  high when result equals 0.
REQ-011 The block SHALL have port out_valid  output  1  result/zero valid.
REQ-012 The block SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-013 The block SHALL decode ALU_control as: 000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL (low WIDTH bits of product), 110 SLT (signed, result 1 or 0); all other codes give result 0.
REQ-014 The block SHALL implement FSM states IDLE, MUL, DONE.
REQ-015 The block SHALL capture ALU_control, src_a and src_b on the edge where in_valid and in_ready are both high; inputs at other times SHALL be ignored.
REQ-016 The block SHALL drive in_ready high only in IDLE.
REQ-017 For non-MUL codes, IDLE SHALL go to DONE on accept; result valid one cycle after accept (latency 1).
REQ-018 For MUL, IDLE SHALL go to MUL on accept; MUL SHALL perform one shift-add step per cycle for exactly WIDTH cycles, then go to DONE (latency WIDTH+1).
REQ-019 Multiplication SHALL be unsigned shift-add with a WIDTH-bit product accumulator; overflow beyond WIDTH bits SHALL be discarded (equals low half of signed product).
REQ-020 ADD/SUB SHALL wrap modulo 2^WIDTH with no overflow flag.
REQ-021 The block SHALL assert out_valid only in DONE; result and zero SHALL hold stable while out_valid is high and out_ready is low.
REQ-022 DONE SHALL go to IDLE on the edge where out_valid and out_ready are both high; no new request is accepted in that same cycle.
REQ-023 The block SHALL compute zero from the registered result, not from in-flight operands.
REQ-024 Changes of src_a, src_b or ALU_control after acceptance SHALL NOT affect the pending result.

Reset
REQ-025 On rst_n low, the block SHALL immediately enter IDLE, with result 0, zero 1, out_valid 0, in_ready 1, iteration counter 0.
REQ-026 Reset asserted mid-MUL or in DONE SHALL abort the operation; the result SHALL be lost and no out_valid SHALL follow.
REQ-027 The first request SHALL be acceptable on the first rising edge after rst_n deasserts.

Configuration
REQ-028 With macro ALU_SEQ_MUL_EN defined, the block SHALL include the MUL state, iteration counter and shift-add datapath per REQ-018/019.
REQ-029 Without ALU_SEQ_MUL_EN, code 101 SHALL be treated as unsupported: result 0, zero 1, latency 1; the MUL state and multiplier logic SHALL be absent.

Verification
REQ-030 The bench SHALL cover: reset, then ADD src_a=5, src_b=7 -> out_valid 1 cycle later, result=12, zero=0.
REQ-031 The bench SHALL cover: SUB src_a=9, src_b=9 -> result=0, zero=1; SLT src_a=0xFFFFFFFF, src_b=1 -> result=1.
REQ-032 The bench SHALL cover: MUL src_a=0x10000, src_b=0x10001 (macro on) -> in_ready low for 33 cycles, out_valid at cycle 33, result=0x00010000.
REQ-033 The bench SHALL cover: ADD 3+4 with out_ready low for 5 cycles -> result=7 held stable with out_valid high, in_valid ignored; on the out_ready edge -> IDLE.
REQ-034 The bench SHALL cover: MUL started, rst_n pulsed low at iteration 10 -> out_valid never rises, outputs at reset values, next ADD 1+1 -> result=2.
REQ-035 The bench SHALL cover: macro off, MUL 6*7 -> result=0, zero=1, latency 1; codes 011 and 111 -> result 0.

Source files
------------

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: handshaked ALU with single-cycle ops and an optional iterative shift-add multiplier.
// Define ALU_SEQ_MUL_EN to include the multiplier (code 101); otherwise 101 yields 0.
module alu_seq_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ALU_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);
`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
    logic [CW-1:0]    cnt;
    logic             is_mul, last;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif
    state_t           state, state_nxt;
    logic [WIDTH-1:0] alu_val;
    logic             accept, slt;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign zero      = result == '0;
    assign accept    = in_valid & in_ready;
    assign slt       = $signed(src_a) < $signed(src_b);

    always_comb begin
        alu_val = ALU_control == 3'b000 ? src_a & src_b :
                  ALU_control == 3'b001 ? src_a | src_b :
                  ALU_control == 3'b010 ? src_a + src_b :
                  ALU_control == 3'b100 ? src_a - src_b :
                  ALU_control == 3'b110 ? {{(WIDTH-1){1'b0}}, slt} : '0;
    end

`ifdef ALU_SEQ_MUL_EN
    assign is_mul  = ALU_control == 3'b101;
    assign last    = cnt == CW'(WIDTH - 1);
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
`endif

    always_comb begin
        state_nxt = state;
        if (state == IDLE && in_valid)
`ifdef ALU_SEQ_MUL_EN
            state_nxt = is_mul ? MUL : DONE;
        if (state == MUL && last)
            state_nxt = DONE;
`else
            state_nxt = DONE;
`endif
        if (state == DONE && out_ready)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // Operands are copied at accept, so later input changes cannot disturb a pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
`ifdef ALU_SEQ_MUL_EN
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
`endif
        end
`ifdef ALU_SEQ_MUL_EN
        else if (accept && is_mul) begin
            mcand  <= src_a;
            mplier <= src_b;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            result <= alu_val;
        end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last) result <= acc_nxt;
        end
`else
        else if (accept) begin
            result <= alu_val;
        end
`endif
    end
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed and randomized checks of alu_seq_exec against an arithmetic reference model.
module tb_alu_seq_exec;
    localparam int W = 32;
    logic         clk, rst_n, in_valid, in_ready, zero, out_valid, out_ready;
    logic [2:0]   ALU_control;
    logic [W-1:0] src_a, src_b, result;
    int           tests = 0, fails = 0;

    alu_seq_exec #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ALU_control(ALU_control), .src_a(src_a), .src_b(src_b),
        .in_valid(in_valid), .in_ready(in_ready), .result(result), .zero(zero),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd4: return a - b;
`ifdef ALU_SEQ_MUL_EN
            3'd5: return p[W-1:0];
`endif
            3'd6: return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op);
`ifdef ALU_SEQ_MUL_EN
        return op == 3'd5 ? W + 1 : 1;
`else
        return op == 3'd5 ? 1 : 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit now);
        logic [W-1:0] e;
        int lat;
        e = model(op, a, b);
        if (!now) @(negedge clk);
        chk("in_ready_before", W'(in_ready), 1);
        ALU_control = op; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ALU_control = 3'($urandom); src_a = $urandom; src_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            chk("in_ready_busy", W'(in_ready), 0);
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency op%0d", op), W'(lat), W'(model_lat(op)));
        chk($sformatf("result op%0d", op), result, e);
        chk("zero", W'(zero), W'(e == 0));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; ALU_control = 3'd2; src_a = $urandom; src_b = $urandom;
            @(posedge clk); #1;
            chk("hold_valid", W'(out_valid), 1);
            chk("hold_result", result, e);
            chk("hold_in_ready", W'(in_ready), 0);
        end
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", W'(out_valid), 0);
        chk("release_idle", W'(in_ready), 1);
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        logic [2:0] op;
        logic [W-1:0] a, b;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ALU_control = 3'd0; src_a = '0; src_b = '0;
        #1;
        chk("rst_result", result, 0);
        chk("rst_zero", W'(zero), 1);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_in_ready", W'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        run(3'd2, 5, 7, 0, 1'b1);
        chk("add5_7", result, 12);
        run(3'd4, 9, 9, 0, 1'b0);
        chk("sub_zero", W'(zero), 1);
        run(3'd6, 32'hFFFF_FFFF, 1, 0, 1'b0);
        run(3'd5, 32'h0001_0000, 32'h0001_0001, 0, 1'b0);
        run(3'd2, 3, 4, 5, 1'b0);
        run(3'd5, 6, 7, 1, 1'b0);
        run(3'd3, 32'h1234, 32'h5678, 0, 1'b0);
        run(3'd7, 32'hFFFF, 32'h1, 0, 1'b0);
        // abort mid-operation (mid-multiply when enabled, otherwise while holding in DONE)
        @(negedge clk);
        ALU_control = 3'd5; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_result", result, 0);
        chk("abort_zero", W'(zero), 1);
        chk("abort_valid", W'(out_valid), 0);
        chk("abort_ready", W'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) chk("abort_no_valid", W'(out_valid), 0);
        end
        chk("abort_still_idle", W'(in_ready), 1);
        run(3'd2, 1, 1, 0, 1'b0);
        chk("add1_1", result, 2);
        for (int n = 0; n < 25; n++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run(op, a, b, $urandom_range(0, 2), 1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
